// File: rtl/hazard_sb.sv
// ============================================================================
// Module   : hazard_sb
// Function : Hazard unit and scoreboard for a 5-stage MIPS-style pipeline.
//            It produces the forwarding selects, the load-use, branch, jr and
//            mult/div stalls, and a multi-cycle mult/div busy tracker.
//            Defining HAZ_STATS_EN adds a saturating stallCount output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sb #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] WriteRegE,
  input  logic [AW-1:0] WriteRegM,
  input  logic [AW-1:0] WriteRegW,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          MemtoRegM,
  input  logic          BranchD,
  input  logic          jrD,
  input  logic          mdStartE,
  input  logic          mdUseD,
  output logic          ForwardAD,
  output logic          ForwardBD,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushE,
`ifdef HAZ_STATS_EN
  output logic [15:0]   stallCount,
`endif
  output logic          mdBusy
);

  localparam logic [3:0]    MD_LOAD = 4'(MD_LAT - 1);
  localparam logic [AW-1:0] ZERO    = '0;

  logic [3:0] mdcnt_q, mdcnt_d;
  logic       lwstall, branchstall, jrstall, mdstall;
  logic       e_hits_d, m_load_hits_d, e_hits_rs, m_load_hits_rs;

  // ALU forwarding: the younger producer in M wins over the one in W.
  always_comb begin
    ForwardAE = 2'b00;
    if (rsE != ZERO && rsE == WriteRegM && RegWriteM)      ForwardAE = 2'b10;
    else if (rsE != ZERO && rsE == WriteRegW && RegWriteW) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (rtE != ZERO && rtE == WriteRegM && RegWriteM)      ForwardBE = 2'b10;
    else if (rtE != ZERO && rtE == WriteRegW && RegWriteW) ForwardBE = 2'b01;
  end

  always_comb begin
    ForwardAD = (rsD != ZERO) && (rsD == WriteRegM) && RegWriteM;
    ForwardBD = (rtD != ZERO) && (rtD == WriteRegM) && RegWriteM;
  end

  always_comb begin
    e_hits_d       = RegWriteE && (WriteRegE != ZERO) &&
                     ((WriteRegE == rsD) || (WriteRegE == rtD));
    m_load_hits_d  = MemtoRegM && (WriteRegM != ZERO) &&
                     ((WriteRegM == rsD) || (WriteRegM == rtD));
    e_hits_rs      = RegWriteE && (WriteRegE != ZERO) && (WriteRegE == rsD);
    m_load_hits_rs = MemtoRegM && (WriteRegM != ZERO) && (WriteRegM == rsD);

    lwstall     = MemtoRegE && (WriteRegE != ZERO) &&
                  ((WriteRegE == rsD) || (WriteRegE == rtD));
    branchstall = BranchD && (e_hits_d || m_load_hits_d);
    jrstall     = jrD && (e_hits_rs || m_load_hits_rs);
    mdstall     = mdUseD && (mdBusy || mdStartE);

    FlushE = lwstall || branchstall || jrstall || mdstall;
    StallF = FlushE;
    StallD = FlushE;
  end

  // A new issue restarts the countdown even if the unit is still busy.
  always_comb begin
    mdcnt_d = mdcnt_q;
    if (mdStartE)            mdcnt_d = MD_LOAD;
    else if (mdcnt_q != 4'd0) mdcnt_d = mdcnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mdcnt_q <= 4'd0;
    else          mdcnt_q <= mdcnt_d;
  end

  assign mdBusy = (mdcnt_q != 4'd0);

`ifdef HAZ_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (FlushE && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_count_q <= 16'd0;
    else          stall_count_q <= stall_count_d;
  end

  assign stallCount = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_sb.sv
// ============================================================================
// Module   : tb_hazard_sb
// Function : Directed self-checking bench for hazard_sb (MD_LAT = 4); the
//            stall-counter section is built only when HAZ_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_sb;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic          BranchD, jrD, mdStartE, mdUseD;
  logic          ForwardAD, ForwardBD, StallF, StallD, FlushE, mdBusy;
  logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZ_STATS_EN
  logic [15:0]   stallCount;
`endif

  hazard_sb #(.AW(AW), .MD_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .jrD(jrD), .mdStartE(mdStartE), .mdUseD(mdUseD),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
`ifdef HAZ_STATS_EN
    .stallCount(stallCount),
`endif
    .mdBusy(mdBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic expect_val(input string tag, input logic [15:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_underflow observed=%0h required=entry", obs);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; jrD = 0;
    mdStartE = 0; mdUseD = 0;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #1;
    expect_val("reset_mdBusy", 16'd0); check({15'd0, mdBusy});
    expect_val("reset_FlushE", 16'd0); check({15'd0, FlushE});
    step();
    reset_n = 1'b1;
    step();

    // Forwarding into E.
    rsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1; WriteRegW = 5'd3; RegWriteW = 1;
    #1;
    expect_val("fwdAE_M", 16'h2); check({14'd0, ForwardAE});
    expect_val("fwdAD_M", 16'h0); check({15'd0, ForwardAD});
    RegWriteM = 0; #1;
    expect_val("fwdAE_W", 16'h1); check({14'd0, ForwardAE});
    rsE = 5'd0; #1;
    expect_val("fwdAE_r0", 16'h0); check({14'd0, ForwardAE});
    rtE = 5'd9; WriteRegM = 5'd9; RegWriteM = 1; rsD = 5'd9; rtD = 5'd9; #1;
    expect_val("fwdBE_M", 16'h2); check({14'd0, ForwardBE});
    expect_val("fwdAD_hit", 16'h1); check({15'd0, ForwardAD});
    expect_val("fwdBD_hit", 16'h1); check({15'd0, ForwardBD});
    clear_inputs(); #1;

    // Load-use stall.
    MemtoRegE = 1; WriteRegE = 5'd5; rtD = 5'd5; #1;
    expect_val("lw_stall", 16'h7); check({13'd0, StallF, StallD, FlushE});
    WriteRegE = 5'd0; rtD = 5'd0; #1;
    expect_val("lw_r0", 16'h0); check({13'd0, StallF, StallD, FlushE});
    clear_inputs(); #1;

    // Branch and jr behind a load in M.
    BranchD = 1; rsD = 5'd7; MemtoRegM = 1; WriteRegM = 5'd7; #1;
    expect_val("branch_stall", 16'h1); check({15'd0, FlushE});
    BranchD = 0; jrD = 1; #1;
    expect_val("jr_stall", 16'h1); check({15'd0, FlushE});
    jrD = 0; #1;
    expect_val("no_ctl_stall", 16'h0); check({15'd0, FlushE});
    clear_inputs(); #1;

    // Single mult/div issue with a dependent consumer held in D.
    mdUseD = 1; mdStartE = 1; #1;
    expect_val("md_issue_flush", 16'h1); check({15'd0, FlushE});
    expect_val("md_issue_busy", 16'h0); check({15'd0, mdBusy});
    step();
    mdStartE = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_val($sformatf("md_busy_%0d", i), 16'h3); check({14'd0, mdBusy, FlushE});
      step();
    end
    #1;
    expect_val("md_done", 16'h0); check({14'd0, mdBusy, FlushE});
    mdUseD = 0;

    // Reload while mdCnt=1 restarts the 3-cycle busy window.
    mdStartE = 1; step(); mdStartE = 0;
    step(); step();
    mdStartE = 1; step(); mdStartE = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_val($sformatf("reload_busy_%0d", i), 16'h1); check({15'd0, mdBusy});
      step();
    end
    #1;
    expect_val("reload_done", 16'h0); check({15'd0, mdBusy});

    // Asynchronous reset between edges abandons the in-flight operation.
    mdStartE = 1; step(); mdStartE = 0;
    #2;
    expect_val("pre_reset_busy", 16'h1); check({15'd0, mdBusy});
    reset_n = 1'b0; #1;
    expect_val("async_reset_busy", 16'h0); check({15'd0, mdBusy});
    #2 reset_n = 1'b1;
    step();
    expect_val("post_reset_busy", 16'h0); check({15'd0, mdBusy});

`ifdef HAZ_STATS_EN
    reset_n = 1'b0; #1; reset_n = 1'b1;
    expect_val("stats_reset", 16'h0); check(stallCount);
    mdUseD = 1; mdStartE = 1;
    step(); step(); step();
    expect_val("stats_three", 16'd3); check(stallCount);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    expect_val("stats_sat", 16'hFFFF); check(stallCount);
    mdUseD = 0; mdStartE = 0;
    #2 reset_n = 1'b0; #1;
    expect_val("stats_cleared", 16'h0); check(stallCount);
    reset_n = 1'b1;
`endif

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_leftover observed=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 The module SHALL have parameter AW, default 5, meaning register-address width (2**AW architectural registers, register 0 hard-wired zero).
REQ-002 The module SHALL have parameter MD_LAT, default 4, meaning multiply/divide latency in cycles from E entry to HI/LO valid; legal range 2..15.
REQ-003 The module SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 The module SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 The module SHALL have ports rsD, rtD, rsE and rtE, input, AW, meaning source register addresses in Decode and Execute.
REQ-006 The module SHALL have ports WriteRegE, WriteRegM and WriteRegW, input, AW, meaning destination register addresses in Execute, Memory and Writeback.
REQ-007 The module SHALL have ports RegWriteE, RegWriteM and RegWriteW, input, 1, meaning the register-write enable per stage.
REQ-008 The module SHALL have ports MemtoRegE and MemtoRegM, input, 1, meaning a load is present in that stage.
REQ-009 The module SHALL have port BranchD, input, 1, meaning a beq or bne is in Decode.
REQ-010 The module SHALL have port jrD, input, 1, meaning a jr is in Decode.
REQ-011 The module SHALL have port mdStartE, input, 1, meaning a mult/div is issuing in Execute this cycle.
REQ-012 The module SHALL have port mdUseD, input, 1, meaning the Decode instruction is mfhi, mflo, mult or div.
REQ-013 The module SHALL have ports ForwardAD and ForwardBD, output, 1, meaning Decode comparator operand forwarding from M.
REQ-014 The module SHALL have ports ForwardAE and ForwardBE, output, 2, meaning ALU operand select: 00 = regfile, 01 = W, 10 = M.
REQ-015 The module SHALL have ports StallF, StallD and FlushE, output, 1, meaning hold PC, hold IF/ID, and bubble ID/EX.
REQ-016 The module SHALL have port mdBusy, output, 1, meaning the mult/div unit is still computing.
REQ-017 The module SHALL have port stallCount, output, 16, meaning the saturating stall-cycle count; the port is present only with HAZ_STATS_EN.

Function
REQ-018 ForwardAE SHALL be 10 if rsE!=0 & rsE==WriteRegM & RegWriteM, else 01 if rsE!=0 & rsE==WriteRegW & RegWriteW, else 00; ForwardBE SHALL follow the same rule using rtE.
REQ-019 ForwardAD SHALL be (rsD!=0 & rsD==WriteRegM & RegWriteM), and ForwardBD SHALL be the same rule using rtD.
REQ-020 lwstall SHALL be MemtoRegE & WriteRegE!=0 & (WriteRegE==rsD | WriteRegE==rtD).
REQ-021 branchstall SHALL be BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE∈{rsD,rtD}) | (MemtoRegM & WriteRegM!=0 & WriteRegM∈{rsD,rtD})).
REQ-022 jrstall SHALL be jrD & ((RegWriteE & WriteRegE!=0 & WriteRegE==rsD) | (MemtoRegM & WriteRegM!=0 & WriteRegM==rsD)).
REQ-023 mdstall SHALL be mdUseD & (mdBusy | mdStartE).
REQ-024 FlushE SHALL be lwstall | branchstall | jrstall | mdstall, and StallF and StallD SHALL both equal FlushE; all outputs SHALL be zero-delay combinational except mdBusy and stallCount.
REQ-025 The module SHALL contain a busy counter mdCnt, 4 bits wide, with mdBusy = (mdCnt!=0).
REQ-026 At a rising edge with mdStartE=1, mdCnt SHALL load MD_LAT-1.
REQ-027 At a rising edge with mdStartE=0 and mdCnt!=0, mdCnt SHALL decrement by 1.
REQ-028 At a rising edge with mdStartE=0 and mdCnt==0, mdCnt SHALL hold at 0.
REQ-029 If mdStartE=1 while mdBusy=1, mdCnt SHALL reload MD_LAT-1 and restart; load takes priority over decrement.
REQ-030 FlushE SHALL NOT alter mdCnt, because the instruction in E is valid in the cycle it issues.

Reset
REQ-031 reset_n=0 SHALL immediately clear mdCnt, giving mdBusy=0, and SHALL clear stallCount, independent of clk.
REQ-032 Reset asserted mid-operation SHALL abandon any in-flight mult/div tracking, and the first edge after release SHALL obey REQ-026 to REQ-028.

Configuration
REQ-033 With macro HAZ_STATS_EN defined, stallCount SHALL increment on each rising edge where FlushE=1 and SHALL saturate at 16'hFFFF.
REQ-034 With HAZ_STATS_EN undefined, the stallCount port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 The bench SHALL apply rsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 and check ForwardAE=10; with RegWriteM=0 it SHALL check 01; with rsE=0 it SHALL check 00.
REQ-036 The bench SHALL apply MemtoRegE=1, WriteRegE=5, rtD=5 and check StallF=StallD=FlushE=1; with WriteRegE=0 it SHALL check all three are 0.
REQ-037 The bench SHALL apply BranchD=1, rsD=7, MemtoRegM=1, WriteRegM=7 and check FlushE=1; with jrD=1 and rsD=7 in place of the branch it SHALL also check FlushE=1.
REQ-038 With MD_LAT=4, the bench SHALL pulse mdStartE for 1 cycle and check mdBusy=1 for exactly 3 cycles; with mdUseD=1 held throughout, it SHALL check FlushE=1 on the issue cycle plus those 3 cycles, then 0.
REQ-039 The bench SHALL assert mdStartE again when mdCnt=1 and check a reload to 3; it SHALL then drop reset_n mid-busy between clock edges and check mdBusy=0 immediately.
REQ-040 With HAZ_STATS_EN defined, the bench SHALL force FlushE=1 for 70000 cycles and check that stallCount saturates at FFFF and is 0 after reset.
